// File: rtl/port_out_hs.sv
// Latched/strobed output port with an OBF/ACK handshake and interrupt request.
// Define PORT_OUT_ACK_SYNC_EN to pass ack_n through a 2-flop synchronizer before edge detection.
module port_out_hs #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mode,
  input  logic             wr_n,
  input  logic [WIDTH-1:0] din,
  input  logic             inte_set,
  input  logic             inte_clr,
  input  logic             ack_n,
  output logic [WIDTH-1:0] pout,
  output logic             obf_n,
  output logic             intr
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFull  = 2'd1,
    StAcked = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic [WIDTH-1:0] wdat_q, wdat_d;
  logic             wr_q, wr_d;
  logic             wdet_q, wdet_d;
  logic             ack_q, ack_d;
  logic             ack_prev_q, ack_prev_d;
  logic             mode_q, mode_d;
  logic             inte_q, inte_d;
  logic             intr_q, intr_d;
  logic             ack_fall, ack_rise;

`ifdef PORT_OUT_ACK_SYNC_EN
  logic             ack_meta_q, ack_meta_d;
`endif

  // ack_q is the conditioned ack; edges are taken against its previous value.
  assign ack_fall = ack_prev_q & ~ack_q;
  assign ack_rise = ~ack_prev_q & ack_q;

  always_comb begin
    wr_d       = wr_n;
    wdet_d     = wr_q & ~wr_n;
    wdat_d     = din;
    pout_d     = wdet_q ? wdat_q : pout_q;
`ifdef PORT_OUT_ACK_SYNC_EN
    ack_meta_d = ack_n;
    ack_d      = ack_meta_q;
`else
    ack_d      = ack_n;
`endif
    ack_prev_d = ack_q;
    mode_d     = mode;
    state_d    = state_q;
    intr_d     = intr_q;

    if (inte_clr) begin
      inte_d = 1'b0;
    end else if (inte_set) begin
      inte_d = 1'b1;
    end else begin
      inte_d = inte_q;
    end

    // Mode change and basic mode both park the handshake; a write beats any ack edge.
    if ((mode != mode_q) || !mode) begin
      state_d = StIdle;
      intr_d  = 1'b0;
    end else if (wdet_q) begin
      state_d = StFull;
      intr_d  = 1'b0;
    end else begin
      case (state_q)
        StFull: begin
          if (ack_fall) state_d = StAcked;
        end
        StAcked: begin
          if (ack_rise) begin
            state_d = StIdle;
            intr_d  = inte_q;
          end
        end
        StIdle: ;
        default: state_d = StIdle;
      endcase
    end

    if (!inte_d) intr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      pout_q     <= RESET_VAL;
      wdat_q     <= RESET_VAL;
      wr_q       <= 1'b1;
      wdet_q     <= 1'b0;
      ack_q      <= 1'b1;
      ack_prev_q <= 1'b1;
`ifdef PORT_OUT_ACK_SYNC_EN
      ack_meta_q <= 1'b1;
`endif
      mode_q     <= mode;
      inte_q     <= 1'b0;
      intr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pout_q     <= pout_d;
      wdat_q     <= wdat_d;
      wr_q       <= wr_d;
      wdet_q     <= wdet_d;
      ack_q      <= ack_d;
      ack_prev_q <= ack_prev_d;
`ifdef PORT_OUT_ACK_SYNC_EN
      ack_meta_q <= ack_meta_d;
`endif
      mode_q     <= mode_d;
      inte_q     <= inte_d;
      intr_q     <= intr_d;
    end
  end

  assign pout  = pout_q;
  assign obf_n = (state_q != StFull);
  assign intr  = intr_q;

endmodule
